// File: rtl/divider_arbiter_if.sv
// Handshake bundle between the requesters, the shared divider and the
// response consumer of divider_arbiter.
`timescale 1ns/1ps
interface divider_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRACTIONBIT = 16
);
  localparam int unsigned FRAC_W = FRACTIONBIT + 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data_u;
  logic [NUM_REQ*WIDTH-1:0] req_data_d;
  logic [WIDTH-1:0]         div_data_u;
  logic [WIDTH-1:0]         div_data_d;
  logic                     div_valid;
  logic [FRAC_W-1:0]        div_fraction;
  logic                     div_done;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [FRAC_W-1:0]        rsp_fraction;
  logic                     rsp_err;
  logic                     busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_data_u, req_data_d, div_fraction, div_done, rsp_ready,
    output req_ready, div_data_u, div_data_d, div_valid,
           rsp_valid, rsp_id, rsp_fraction, rsp_err, busy
  );

  // Environment side (requesters, divider, response consumer)
  modport master (
    output req_valid, req_data_u, req_data_d, div_fraction, div_done, rsp_ready,
    input  req_ready, div_data_u, div_data_d, div_valid,
           rsp_valid, rsp_id, rsp_fraction, rsp_err, busy
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter that time-shares one sequential fractional divider
// between NUM_REQ requesters, with a watchdog on the divider done pulse.
// Optional macro DIVARB_ZERO_BYPASS_EN: a zero denominator is answered
// directly with an all-ones quotient and rsp_err=1, without using the divider.
`timescale 1ns/1ps
module divider_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRACTIONBIT = 16,
  parameter int unsigned TIMEOUT     = 40
) (
  input logic              clk,
  input logic              rst_n,
  divider_arbiter_if.slave bus
);
  localparam int unsigned FRAC_W = FRACTIONBIT + 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gid_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_nxt;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [ID_W-1:0]    grant_id;
  logic [WIDTH-1:0]   grant_u;
  logic [WIDTH-1:0]   grant_d;

  // Round-robin search: first valid request after rr_ptr, wrapping around
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i] &&
            ((32'(rr_ptr) + k == i) || (32'(rr_ptr) + k == i + NUM_REQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Operand and ID mux for the one-hot grant
  always_comb begin
    grant_id = '0;
    grant_u  = '0;
    grant_d  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        grant_u  = bus.req_data_u[i*WIDTH +: WIDTH];
        grant_d  = bus.req_data_d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grants are only offered while idle
  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign wait_nxt      = wait_cnt + CNT_W'(1);

  // Job sequencing: grant, divider launch, watchdog wait, response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= ID_W'(NUM_REQ - 1);
      gid_q            <= '0;
      wait_cnt         <= '0;
      bus.div_data_u   <= '0;
      bus.div_data_d   <= '0;
      bus.div_valid    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_fraction <= '0;
      bus.rsp_err      <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gid_q          <= grant_id;
            bus.div_data_u <= grant_u;
            bus.div_data_d <= grant_d;
            bus.busy       <= 1'b1;
`ifdef DIVARB_ZERO_BYPASS_EN
            if (grant_d == '0) begin
              state            <= RESP;
              bus.rsp_valid    <= 1'b1;
              bus.rsp_id       <= grant_id;
              bus.rsp_fraction <= '1;
              bus.rsp_err      <= 1'b1;
            end else begin
              state         <= START;
              bus.div_valid <= 1'b1;
            end
`else
            state         <= START;
            bus.div_valid <= 1'b1;
`endif
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_nxt;
          if (bus.div_done) begin
            state            <= RESP;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_id       <= gid_q;
            bus.rsp_fraction <= bus.div_fraction;
            bus.rsp_err      <= 1'b0;
          end else if (wait_nxt == CNT_W'(TIMEOUT)) begin
            state            <= RESP;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_id       <= gid_q;
            bus.rsp_fraction <= '0;
            bus.rsp_err      <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            rr_ptr        <= gid_q;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Shares one sequential fractional divider (17-bit Q1.16 result, one-cycle start pulse, one-cycle done pulse roughly FRACTIONBIT+2 cycles later) between NUM_REQ requesters in the k-remapping pipeline. Round-robin arbitration picks a request, the block launches the divider and watches its done pulse, then returns the quotient tagged with the requester ID. A watchdog guards against a lost done pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ
WIDTH, 16, numerator/denominator width
FRACTIONBIT, 16, divider fraction bits; quotient width FRACTIONBIT+1
TIMEOUT, 40, max WAIT cycles before error (1..255; must exceed divider latency)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held with operands until granted
req_ready  out  NUM_REQ  one-hot grant, combinational; handshake = valid&ready
req_data_u  in  NUM_REQ*WIDTH  numerators; slot i at [i*WIDTH +: WIDTH]
req_data_d  in  NUM_REQ*WIDTH  denominators, same packing
div_data_u  out  WIDTH  numerator to divider, registered, held through WAIT
div_data_d  out  WIDTH  denominator to divider, registered, held through WAIT
div_valid  out  1  single-cycle start pulse to divider
div_fraction  in  FRACTIONBIT+1  divider quotient
div_done  in  1  divider done pulse
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response accept
rsp_id  out  ID_W  ID of the requester being answered
rsp_fraction  out  FRACTIONBIT+1  quotient (Q1.16)
rsp_err  out  1  1 = timeout (or zero denominator with the optional feature)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: FSM=IDLE. rr_ptr=NUM_REQ-1, so requester 0 has first priority. All outputs 0, wait counter 0. Reset mid-operation aborts the job; no response is ever produced for it.
- States: IDLE, START, WAIT, RESP.
- IDLE: req_ready = one-hot of the first asserted req_valid searching from rr_ptr+1 upward (wrapping). It is 0 in every other state.
  - On handshake: latch the granted operands into div_data_*, latch grant ID, go to START.
- START: div_valid=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - On div_done=1: capture div_fraction into rsp_fraction, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT: set rsp_fraction=0, rsp_err=1, go to RESP.
  - If div_done and timeout occur in the same cycle, done wins.
- div_done outside WAIT (including the divider's spurious post-reset pulse) is ignored.
- RESP: rsp_valid=1; rsp_id, rsp_fraction and rsp_err stay stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid drops next cycle, rr_ptr <= granted ID, go to IDLE.
  - Minimum gap between grants: 3 cycles plus divider latency.
- Operand registers keep their value after the job so the divider input stays stable.
- busy = (state != IDLE).
- Requests arriving while the block is busy wait with req_ready=0. No request is dropped. Fairness: a continuously asserted request is granted within NUM_REQ jobs.

Optional Feature:
DIVARB_ZERO_BYPASS_EN
- Defined: if the granted denominator is 0, skip START/WAIT. Go IDLE->RESP directly with rsp_fraction = all ones (0x1FFFF at defaults) and rsp_err=1; div_valid is not pulsed.
- Undefined: zero denominators go to the divider like any other job and return whatever the divider produces, with rsp_err=0 (unless the job times out).

Test Plan:
- Reset, then only req 0 valid with u=1, d=2, rsp_ready=1 -> one div_valid pulse; rsp_valid the cycle after div_done; rsp_id=0, rsp_fraction=0x08000, rsp_err=0.
- Reqs 0..3 valid together with u=3, d=4 -> grants in order 0,1,2,3; four responses 0x0C000 with matching rsp_id; exactly one req_ready bit high per grant.
- Req 1 valid continuously, req 2 pulsed after req 1 is served -> req 2 granted before req 1's next grant (round-robin rotation).
- Divider model never pulses done -> rsp_valid with rsp_err=1, rsp_fraction=0 exactly TIMEOUT+1 cycles after START; the late or spurious done is ignored in IDLE.
- u=5, d=5 with rsp_ready held low for 10 cycles -> rsp_valid, rsp_fraction=0x10000 and rsp_id stay stable; no new grant until accepted.
- With DIVARB_ZERO_BYPASS_EN, d=0 -> no div_valid, rsp_fraction=0x1FFFF, rsp_err=1 in the cycle after grant. Without the macro, the job goes through the divider. Assert rst_n mid-WAIT -> all outputs return to 0 and no response is produced.
